// File: rtl/seg7_pkg.sv
// Shared constants for the active-low 7-segment display bus.
// Also holds the helper that finds the single low bit of a digit-enable bus.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam int SEGBIT_A = 0;
   localparam int SEGBIT_B = 1;
   localparam int SEGBIT_C = 2;
   localparam int SEGBIT_D = 3;
   localparam int SEGBIT_E = 4;
   localparam int SEGBIT_F = 5;
   localparam int SEGBIT_G = 6;

   typedef struct packed {
      logic       legal;
      logic [4:0] idx;
   } onehot_t;

   // Unused upper bits must be padded with 1s so they read as inactive.
   function automatic onehot_t onehot_low_idx(input logic [31:0] v_n);
      onehot_t     res;
      int unsigned zeros;
      res.legal = 1'b0;
      res.idx   = 5'd0;
      zeros     = 0;
      for (int k = 0; k < 32; k++) begin
         if (v_n[k] == 1'b0) begin
            zeros   = zeros + 1;
            res.idx = 5'(k);
         end
      end
      res.legal = (zeros == 32'd1);
      return res;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse of the hex-to-segment encoding: classifies an active-low segment
// pattern as a hex glyph, the blank pattern, or neither.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] hex,
   output logic       is_hex,
   output logic       is_blank
);

   // Glyph lookup; anything not listed is illegal.
   always_comb begin
      hex      = 4'h0;
      is_hex   = 1'b1;
      is_blank = 1'b0;
      case (seg_n)
         SEG_0:     hex = 4'h0;
         SEG_1:     hex = 4'h1;
         SEG_2:     hex = 4'h2;
         SEG_3:     hex = 4'h3;
         SEG_4:     hex = 4'h4;
         SEG_5:     hex = 4'h5;
         SEG_6:     hex = 4'h6;
         SEG_7:     hex = 4'h7;
         SEG_8:     hex = 4'h8;
         SEG_9:     hex = 4'h9;
         SEG_A:     hex = 4'hA;
         SEG_B:     hex = 4'hB;
         SEG_C:     hex = 4'hC;
         SEG_D:     hex = 4'hD;
         SEG_E:     hex = 4'hE;
         SEG_F:     hex = 4'hF;
         SEG_BLANK: begin
            is_hex   = 1'b0;
            is_blank = 1'b1;
         end
         default: begin
            is_hex   = 1'b0;
            is_blank = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed common-anode 7-segment bus, capturing one digit
// per stable dwell and flagging completed frames and illegal glyphs.
module seg7_scan_reader
   import seg7_pkg::*;
#(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 8
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NDIG-1:0]         an_n,
   input  logic [6:0]              seg_n,
   output logic [4*NDIG-1:0]       digits,
   output logic [NDIG-1:0]         digit_valid,
   output logic                    frame_valid,
   output logic                    err,
   output logic [$clog2(NDIG)-1:0] err_idx
);

   localparam int         IW      = $clog2(NDIG);
   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC);
   localparam logic [7:0] CNT_CAP = 8'(STABLE_CYC - 1);

   logic [NDIG-1:0]   an_m_r, an_s_r, an_p_r;
   logic [6:0]        seg_m_r, seg_s_r, seg_p_r;
   logic [7:0]        cnt_r, cnt_nxt_s;
   onehot_t           oh_s;
   logic              stable_s, capture_s;
   logic [IW-1:0]     cap_idx_s;
   logic [3:0]        hex_s;
   logic              is_hex_s, is_blank_s;

   logic [4*NDIG-1:0] digits_r, digits_nxt_s;
   logic [NDIG-1:0]   valid_r, valid_nxt_s;
   logic [NDIG-1:0]   seen_r, seen_nxt_s;
   logic              frame_r, frame_nxt_s;
   logic              err_r, err_nxt_s;
   logic [IW-1:0]     err_idx_r, err_idx_nxt_s;

   seg7_pattern_decode u_decode (
      .seg_n    (seg_s_r),
      .hex      (hex_s),
      .is_hex   (is_hex_s),
      .is_blank (is_blank_s)
   );

   assign oh_s      = onehot_low_idx({{(32-NDIG){1'b1}}, an_s_r});
   assign cap_idx_s = IW'(oh_s.idx);
   assign stable_s  = ({an_s_r, seg_s_r} == {an_p_r, seg_p_r});
   assign capture_s = stable_s && oh_s.legal && (cnt_r == CNT_CAP);

   // Two-flop synchronisers plus the previous-sample register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_m_r  <= {NDIG{1'b0}};
         an_s_r  <= {NDIG{1'b0}};
         an_p_r  <= {NDIG{1'b0}};
         seg_m_r <= 7'd0;
         seg_s_r <= 7'd0;
         seg_p_r <= 7'd0;
      end else begin
         an_m_r  <= an_n;
         an_s_r  <= an_m_r;
         an_p_r  <= an_s_r;
         seg_m_r <= seg_n;
         seg_s_r <= seg_m_r;
         seg_p_r <= seg_s_r;
      end
   end

   // Stability counter: restarts on any change or a non-one-hot enable bus.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (!stable_s || !oh_s.legal) begin
         cnt_nxt_s = 8'd0;
      end else if (cnt_r < CNT_MAX) begin
         cnt_nxt_s = cnt_r + 8'd1;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Capture outcome and frame bookkeeping.
   always_comb begin
      digits_nxt_s  = digits_r;
      valid_nxt_s   = valid_r;
      seen_nxt_s    = seen_r;
      frame_nxt_s   = 1'b0;
      err_nxt_s     = 1'b0;
      err_idx_nxt_s = err_idx_r;
      if (capture_s) begin
         seen_nxt_s[cap_idx_s] = 1'b1;
         if (is_hex_s) begin
            digits_nxt_s[{cap_idx_s, 2'b00} +: 4] = hex_s;
            valid_nxt_s[cap_idx_s]                = 1'b1;
         end else if (is_blank_s) begin
            valid_nxt_s[cap_idx_s] = 1'b0;
         end else begin
            valid_nxt_s[cap_idx_s] = 1'b0;
            err_nxt_s              = 1'b1;
            err_idx_nxt_s          = cap_idx_s;
         end
         if (&seen_nxt_s) begin
            frame_nxt_s = 1'b1;
            seen_nxt_s  = {NDIG{1'b0}};
         end else begin
            frame_nxt_s = 1'b0;
         end
      end else begin
         seen_nxt_s = seen_r;
      end
   end

   // Counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r     <= 8'd0;
         digits_r  <= {(4*NDIG){1'b0}};
         valid_r   <= {NDIG{1'b0}};
         seen_r    <= {NDIG{1'b0}};
         frame_r   <= 1'b0;
         err_r     <= 1'b0;
         err_idx_r <= {IW{1'b0}};
      end else begin
         cnt_r     <= cnt_nxt_s;
         digits_r  <= digits_nxt_s;
         valid_r   <= valid_nxt_s;
         seen_r    <= seen_nxt_s;
         frame_r   <= frame_nxt_s;
         err_r     <= err_nxt_s;
         err_idx_r <= err_idx_nxt_s;
      end
   end

   assign digits      = digits_r;
   assign digit_valid = valid_r;
   assign frame_valid = frame_r;
   assign err         = err_r;
   assign err_idx     = err_idx_r;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: directed vector table, corner
// sequences, and randomized dwells against a transaction-level model.
module tb_seg7_scan_reader;

   localparam int NDIG = 4;
   localparam int S    = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        frame_valid;
   logic        err;
   logic [1:0]  err_idx;

   seg7_scan_reader #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .an_n        (an_n),
      .seg_n       (seg_n),
      .digits      (digits),
      .digit_valid (digit_valid),
      .frame_valid (frame_valid),
      .err         (err),
      .err_idx     (err_idx)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int failures  = 0;
   int frame_cnt = 0;
   int err_cnt   = 0;

   logic [6:0] glyph [16];

   always @(negedge clk) begin
      if (frame_valid === 1'b1) frame_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      int          hold;
      logic [15:0] exp_d;
      logic [3:0]  exp_v;
      int          exp_f;
      int          exp_e;
      logic [1:0]  exp_ei;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      an_n  = a;
      seg_n = s;
      step(n);
   endtask

   task automatic idle(input int n);
      drive(4'hF, 7'h7F, n);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_digits"}, 32'(digits), 32'd0);
      chk({tag, "_valid"}, 32'(digit_valid), 32'd0);
      chk({tag, "_frame"}, 32'(frame_valid), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_err_idx"}, 32'(err_idx), 32'd0);
   endtask

   // -1 = blank, -2 = illegal, else hex value
   function automatic int model_decode(input logic [6:0] s);
      int r;
      r = (s == 7'h7F) ? -1 : -2;
      for (int k = 0; k < 16; k++) if (glyph[k] == s) r = k;
      return r;
   endfunction

   // transaction-level model state
   logic [3:0] m_dig [4];
   logic [3:0] m_val;
   logic [3:0] m_seen;
   int         m_frames, m_errs;
   logic [1:0] m_eidx;

   task automatic model_capture(input int i, input logic [6:0] s);
      int d;
      d = model_decode(s);
      m_seen[i] = 1'b1;
      if (d >= 0) begin
         m_dig[i] = 4'(d);
         m_val[i] = 1'b1;
      end else begin
         m_val[i] = 1'b0;
         if (d == -2) begin
            m_errs++;
            m_eidx = 2'(i);
         end
      end
      if (m_seen == 4'hF) begin
         m_frames++;
         m_seen = 4'h0;
      end
   endtask

   initial begin
      int lat, f0, e0, idx, len, kind;
      logic [3:0] a, pa;
      logic [6:0] s, ps;

      glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
      glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
      glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
      glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;

      vt[0] = '{4'hE, 7'h30, 20, 16'h0003, 4'h1, 0, 0, 2'd0};
      vt[1] = '{4'hE, 7'h79, 12, 16'h0001, 4'h1, 0, 0, 2'd0};
      vt[2] = '{4'hD, 7'h08, 12, 16'h00A1, 4'h3, 0, 0, 2'd0};
      vt[3] = '{4'hB, 7'h0E, 12, 16'h0FA1, 4'h7, 0, 0, 2'd0};
      vt[4] = '{4'h7, 7'h00, 12, 16'h8FA1, 4'hF, 1, 0, 2'd0};
      vt[5] = '{4'hD, 7'h55, 12, 16'h8FA1, 4'hD, 0, 1, 2'd1};
      vt[6] = '{4'hD, 7'h7F, 12, 16'h8FA1, 4'hD, 0, 0, 2'd1};
      vt[7] = '{4'hC, 7'h30, 50, 16'h8FA1, 4'hD, 0, 0, 2'd1};
      vt[8] = '{4'hF, 7'h30, 50, 16'h8FA1, 4'hD, 0, 0, 2'd1};

      // reset state
      rst_n = 1'b0;
      an_n  = 4'hF;
      seg_n = 7'h7F;
      step(3);
      #1;
      check_zero("reset");
      rst_n = 1'b1;
      step(3);

      // latency of the first capture
      an_n  = 4'hE;
      seg_n = 7'h30;
      lat   = 0;
      while (digit_valid[0] !== 1'b1 && lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
      end
      chk("latency_in_10_to_12", 32'((lat >= 10) && (lat <= 12)), 32'd1);
      if (lat < 10 || lat > 12) $display("  latency measured %0d cycles", lat);
      @(negedge clk);
      step(8);
      #1;
      chk("lat_digit0", 32'(digits[3:0]), 32'd3);
      chk("lat_no_err", 32'(err_cnt), 32'd0);
      idle(14);

      // directed vector table
      for (int v = 0; v < 9; v++) begin
         f0 = frame_cnt;
         e0 = err_cnt;
         drive(vt[v].an, vt[v].seg, vt[v].hold);
         idle(14);
         #1;
         chk($sformatf("vec%0d_digits", v), 32'(digits), 32'(vt[v].exp_d));
         chk($sformatf("vec%0d_valid", v), 32'(digit_valid), 32'(vt[v].exp_v));
         chk($sformatf("vec%0d_frames", v), 32'(frame_cnt - f0), 32'(vt[v].exp_f));
         chk($sformatf("vec%0d_errs", v), 32'(err_cnt - e0), 32'(vt[v].exp_e));
         chk($sformatf("vec%0d_err_idx", v), 32'(err_idx), 32'(vt[v].exp_ei));
      end

      // glitchy digit 2: toggles too fast to ever capture
      f0 = frame_cnt;
      e0 = err_cnt;
      for (int k = 0; k < 12; k++) drive(4'hB, (k % 2 == 0) ? 7'h40 : 7'h79, 5);
      idle(14);
      #1;
      chk("toggle_digits", 32'(digits), 32'h8FA1);
      chk("toggle_valid", 32'(digit_valid), 32'hD);
      chk("toggle_frames", 32'(frame_cnt - f0), 32'd0);
      chk("toggle_errs", 32'(err_cnt - e0), 32'd0);

      // reset mid-frame and mid-dwell restarts the frame
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      idle(4);
      drive(4'hE, 7'h79, 12); idle(4);
      drive(4'hD, 7'h24, 12); idle(4);
      drive(4'hB, 7'h30, 12); idle(4);
      drive(4'h7, 7'h19, 5);
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      step(1);
      rst_n = 1'b1;
      idle(4);
      f0 = frame_cnt;
      drive(4'h7, 7'h19, 12); idle(4);
      drive(4'hE, 7'h79, 12); idle(4);
      drive(4'hD, 7'h24, 12); idle(4);
      #1;
      chk("midrst_no_frame_yet", 32'(frame_cnt - f0), 32'd0);
      drive(4'hB, 7'h30, 12); idle(14);
      #1;
      chk("midrst_frame", 32'(frame_cnt - f0), 32'd1);
      chk("midrst_digits", 32'(digits), 32'h4321);
      chk("midrst_valid", 32'(digit_valid), 32'hF);

      // randomized dwells against the transaction model
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      idle(4);
      for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
      m_val = 4'h0; m_seen = 4'h0; m_frames = 0; m_errs = 0; m_eidx = 2'd0;
      f0 = frame_cnt;
      e0 = err_cnt;
      for (int r = 0; r < 6; r++) begin
         pa = 4'hF;
         ps = 7'h7F;
         for (int d = 0; d < 15; d++) begin
            do begin
               kind = int'($urandom_range(0, 9));
               idx  = int'($urandom_range(0, 3));
               if (kind < 8) a = 4'hF & ~(4'h1 << idx);
               else if (kind == 8) a = 4'hF;
               else a = 4'hF & ~(4'h1 << idx) & ~(4'h1 << ((idx + 1 + int'($urandom_range(0, 2))) % 4));
               kind = int'($urandom_range(0, 19));
               if (kind < 12) s = glyph[$urandom_range(0, 15)];
               else if (kind < 15) s = 7'h7F;
               else s = 7'($urandom);
            end while (a == pa && s == ps);
            len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, S - 1))
                                              : int'($urandom_range(S + 2, S + 10));
            if (len > S + 1 && (a == 4'hE || a == 4'hD || a == 4'hB || a == 4'h7)) begin
               for (int k = 0; k < 4; k++) if (a[k] == 1'b0) model_capture(k, s);
            end
            drive(a, s, len);
            pa = a;
            ps = s;
         end
         idle(16);
         #1;
         chk($sformatf("rnd%0d_digits", r), 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
         chk($sformatf("rnd%0d_valid", r), 32'(digit_valid), 32'(m_val));
         chk($sformatf("rnd%0d_frames", r), 32'(frame_cnt - f0), 32'(m_frames));
         chk($sformatf("rnd%0d_errs", r), 32'(err_cnt - e0), 32'(m_errs));
         chk($sformatf("rnd%0d_err_idx", r), 32'(err_idx), 32'(m_eidx));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Reads back a time-multiplexed, active-low 7-segment display bus: common-anode digit enables plus shared segment lines.
- Recovers the hex value shown on each digit, using the inverse of the team's hex-to-segment encoding.
- Sits beside the display driver as a loopback/self-check monitor, or reads an external display into the design.
- Filters glitches with a stability counter, captures one digit per dwell, and flags complete frames and illegal patterns.

Parameters:
- NDIG, 4: number of multiplexed digits; width of the enable bus.
- STABLE_CYC, 8: consecutive identical synchronised samples required before capture; legal range 2..255.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- an_n  input  NDIG  digit enables, active-low, one-hot-low when legal.
- seg_n  input  7  segment lines, active-low; bit0 = a … bit6 = g.
- digits  output  4*NDIG  captured hex value; digit i is at bits [4i+3:4i].
- digit_valid  output  NDIG  1 = digit i holds a legal hex glyph from its latest capture.
- frame_valid  output  1  one-cycle pulse when every digit has been captured since the last pulse.
- err  output  1  one-cycle pulse when a captured pattern is neither a hex glyph nor blank.
- err_idx  output  $clog2(NDIG)  digit index of the latest err; holds its value between errors.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, plus synchroniser flops, counter and seen mask. On release, the sync flops load 1s on the first edge, so the bus reads as idle.
- Synchronisation: an_n and seg_n each pass through a 2-flop synchroniser, giving an_s and seg_s. A third register holds the previous sample, {an_p, seg_p}.
- Stability counter cnt, 8 bits:
  - cleared to 0 when {an_s, seg_s} != {an_p, seg_p};
  - also cleared when an_s is not exactly one-hot-low (all-high = idle, or more than one low);
  - otherwise incremented, saturating at STABLE_CYC.
- Capture fires in the single cycle where cnt == STABLE_CYC-1 and the sample is stable and one-hot. It fires exactly once per dwell; a saturated counter does not re-fire.
- Capture effects, written on the clock edge (visible the cycle after capture):
  - Let i be the index of the low bit in an_s.
  - seen[i] <= 1 for every capture outcome.
  - Hex glyph: digits[i] <= value; digit_valid[i] <= 1.
  - Blank (seg_s == 7'h7F): digits[i] unchanged; digit_valid[i] <= 0.
  - Any other pattern: digit_valid[i] <= 0; err <= 1 for one cycle; err_idx <= i; digits[i] unchanged.
- Latency: from the input edge to the updated output is 2 (sync) + 1 (compare) + STABLE_CYC cycles, ±1 cycle depending on sample phase.
- Frame completion:
  - When the next-state seen mask would be all 1s, frame_valid <= 1 for one cycle and seen <= 0.
  - If the completing capture is also an error, frame_valid and err pulse in the same cycle.
  - Recapturing an already-seen digit within a frame updates digits and digit_valid only.
- Decode table (seg_n value → hex): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Reset mid-dwell or mid-frame: the capture is discarded and the frame restarts empty.

Decomposition:
- seg7_pkg:
  - the 16 glyph constants and SEG_BLANK = 7'h7F;
  - the segment-bit index names a..g;
  - helper function onehot_low_idx() returning the index and a legal flag.
- Sub-module seg7_pattern_decode: purely combinational. Inputs seg_n[6:0]; outputs hex[3:0], is_hex, is_blank. Instantiated once on seg_s.

Test Plan:
- Drive an_n = 4'b1110 with seg_n = 7'h30 for 20 cycles (STABLE_CYC = 8) → digits[3:0] = 3 and digit_valid[0] = 1 exactly 11 ±1 cycles after the edge; no err.
- Cycle digits 0..3 with glyphs 1, A, F, 8 (seg_n 79, 08, 0E, 00), 12 cycles each → digits = 16'h8FA1, digit_valid = 4'hF, one frame_valid pulse on the 4th capture.
- On digit 2, toggle seg_n between 0x40 and 0x79 every 5 cycles for 60 cycles → no capture, digit_valid[2] unchanged, no frame_valid.
- Hold digit 1 with seg_n = 7'h55 for 12 cycles → err pulse, err_idx = 1, digit_valid[1] = 0, digits[7:4] unchanged. Then blank (7'h7F) on digit 1 → no err, digit_valid[1] = 0.
- Drive an_n = 4'b1100 (multi-hot) or 4'b1111 (idle) for 50 cycles → no capture, no err, no frame_valid.
- Assert rst_n low for 1 cycle after 3 of 4 digits are captured → all outputs 0. Frame_valid then pulses only after all 4 digits are recaptured.
